// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: arbitrates button presses, filters them, queues directions and commits one per game tick
// Ports: clk, rst (sync, active-high), button_pulse[3:0] (up,down,left,right strobes), tick (game step),
//        pause_sw (level) -> dir_out[1:0], step, paused, fifo_count, drop_cnt (saturating)
// Build option: DIR_REVERSE_FILTER_EN rejects (and counts) presses opposite to the reference direction
module snake_dir_ctrl #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               button_pulse,
    input  logic                     tick,
    input  logic                     pause_sw,
    output logic [1:0]               dir_out,
    output logic                     step,
    output logic                     paused,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [DROP_W-1:0]        drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {RUN, FLUSH, PAUSED} state_t;
    state_t state, state_nx;
    logic [1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, tail_ptr;
    logic [1:0] win, ref_dir;
    logic run, has, cand, opp, full, pop, push, drop_win;
    logic [2:0] losers, drop_inc;
    logic [DROP_W+2:0] drop_sum;
    always_comb begin
        run      = state == RUN;
        has      = |button_pulse;
        win      = button_pulse[0] ? 2'd0 : button_pulse[1] ? 2'd1 : button_pulse[2] ? 2'd2 : 2'd3;
        losers   = {2'b0, button_pulse[0]} + {2'b0, button_pulse[1]} + {2'b0, button_pulse[2]}
                 + {2'b0, button_pulse[3]} - {2'b0, has};
        tail_ptr = wr_ptr - AW'(1);
        ref_dir  = fifo_count != 0 ? mem[tail_ptr] : dir_out;
        full     = fifo_count == CW'(DEPTH);
        pop      = run && tick && fifo_count != 0;
        opp      = 1'b0;
`ifdef DIR_REVERSE_FILTER_EN
        opp      = win[1] == ref_dir[1] && win[0] != ref_dir[0];
`endif
        // a pop in the same cycle frees a slot, so a full FIFO can still accept
        cand     = run && has && win != ref_dir;
        push     = cand && !opp && (!full || pop);
        drop_win = cand && !push;
        drop_inc = run ? losers + {2'b0, drop_win} : 3'd0;
        drop_sum = {3'b0, drop_cnt} + (DROP_W+3)'(drop_inc);
        state_nx = run ? (pause_sw ? FLUSH : RUN) : state == FLUSH ? PAUSED : (pause_sw ? PAUSED : RUN);
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= win;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            dir_out    <= 2'b11;
            step       <= 1'b0;
            paused     <= 1'b0;
            fifo_count <= '0;
            drop_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state    <= state_nx;
            paused   <= state_nx != RUN;
            step     <= run && tick;
            drop_cnt <= drop_sum > (DROP_W+3)'({DROP_W{1'b1}}) ? '1 : drop_sum[DROP_W-1:0];
            if (pop) begin
                dir_out <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (state == FLUSH) begin
                fifo_count <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
            end
        end
    end
endmodule
